// File: rtl/instr_fetch_unit.sv
// PC + fetch stage feeding the control decoder; branch targets come from the LUT_INIT table image.
// Optional performance counters (Cycle_count, Branch_count) are built only when FETCH_PERF_EN is defined.
module instr_fetch_unit #(
  parameter int PC_W    = 10,
  parameter int INSTR_W = 9,
  parameter int LUT_W   = 5,
  parameter logic [(2**LUT_W)*PC_W-1:0] LUT_INIT = {((2**LUT_W)*PC_W){1'b0}}
) (
  input  logic               Clk,
  input  logic               Reset_n,
  input  logic               Start,
  input  logic               Stall,
  input  logic               Branch_take,
  input  logic [LUT_W-1:0]   Branch_idx,
  input  logic               Halt_req,
  output logic [PC_W-1:0]    Rom_addr,
  input  logic [INSTR_W-1:0] Rom_data,
  output logic [INSTR_W-1:0] Instruction,
  output logic               Instr_valid,
  output logic [PC_W-1:0]    Pc,
`ifdef FETCH_PERF_EN
  output logic [15:0]        Cycle_count,
  output logic [7:0]         Branch_count,
`endif
  output logic               Done
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

  localparam logic [PC_W-1:0]    PC_ZERO    = {PC_W{1'b0}};
  localparam logic [PC_W-1:0]    PC_ONE     = {{(PC_W-1){1'b0}}, 1'b1};
  localparam logic [PC_W-1:0]    PC_LAST    = {PC_W{1'b1}};
  localparam logic [INSTR_W-1:0] INSTR_ZERO = {INSTR_W{1'b0}};

  state_t               state_r, state_s;
  logic [PC_W-1:0]      pc_r, pc_s;
  logic [INSTR_W-1:0]   instr_r, instr_s;
  logic                 valid_r, valid_s;
  logic                 done_r, done_s;
  logic [PC_W-1:0]      lut_target_s;
  logic                 start_run_s;
  logic                 branch_hit_s;

  // Read-only branch-target table, combinational lookup
  assign lut_target_s = LUT_INIT[PC_W*int'(Branch_idx) +: PC_W];

  assign start_run_s  = Start && ((state_r == ST_IDLE) || (state_r == ST_HALTED));
  assign branch_hit_s = (state_r == ST_RUN) && !Halt_req && Branch_take;

  // State and datapath registers
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_r <= ST_IDLE;
      pc_r    <= PC_ZERO;
      instr_r <= INSTR_ZERO;
      valid_r <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      pc_r    <= pc_s;
      instr_r <= instr_s;
      valid_r <= valid_s;
      done_r  <= done_s;
    end
  end

  // Next-state and next-datapath selection
  always_comb begin
    state_s = state_r;
    pc_s    = pc_r;
    instr_s = instr_r;
    valid_s = valid_r;
    done_s  = done_r;
    case (state_r)
      ST_IDLE: begin
        if (Start) begin
          state_s = ST_RUN;
          pc_s    = PC_ZERO;
          valid_s = 1'b0;
          done_s  = 1'b0;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        // Halt beats branch, branch beats stall
        if (Halt_req) begin
          state_s = ST_HALTED;
          done_s  = 1'b1;
          valid_s = 1'b0;
        end else if (Branch_take) begin
          pc_s    = lut_target_s;
          instr_s = INSTR_ZERO;
          valid_s = 1'b0;
        end else if (Stall) begin
          state_s = ST_RUN;
        end else begin
          instr_s = Rom_data;
          valid_s = 1'b1;
          if (pc_r == PC_LAST) begin
            state_s = ST_HALTED;
            done_s  = 1'b1;
          end else begin
            pc_s = pc_r + PC_ONE;
          end
        end
      end
      ST_HALTED: begin
        if (Start) begin
          state_s = ST_RUN;
          pc_s    = PC_ZERO;
          valid_s = 1'b0;
          done_s  = 1'b0;
        end else if (!Stall) begin
          valid_s = 1'b0;
        end else begin
          valid_s = valid_r;
        end
      end
      default: begin
        state_s = ST_IDLE;
        pc_s    = PC_ZERO;
        instr_s = INSTR_ZERO;
        valid_s = 1'b0;
        done_s  = 1'b0;
      end
    endcase
  end

  // Output drive from registered state
  always_comb begin
    Rom_addr    = pc_r;
    Pc          = pc_r;
    Instruction = instr_r;
    Instr_valid = valid_r;
    Done        = done_r;
  end

`ifdef FETCH_PERF_EN
  logic [15:0] cycle_cnt_r;
  logic [7:0]  branch_cnt_r;

  // Saturating RUN-cycle and taken-branch counters, cleared when a Start enters RUN
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      cycle_cnt_r  <= 16'd0;
      branch_cnt_r <= 8'd0;
    end else if (start_run_s) begin
      cycle_cnt_r  <= 16'd0;
      branch_cnt_r <= 8'd0;
    end else begin
      if ((state_r == ST_RUN) && (cycle_cnt_r != 16'hFFFF)) begin
        cycle_cnt_r <= cycle_cnt_r + 16'd1;
      end else begin
        cycle_cnt_r <= cycle_cnt_r;
      end
      if (branch_hit_s && (branch_cnt_r != 8'hFF)) begin
        branch_cnt_r <= branch_cnt_r + 8'd1;
      end else begin
        branch_cnt_r <= branch_cnt_r;
      end
    end
  end

  assign Cycle_count  = cycle_cnt_r;
  assign Branch_count = branch_cnt_r;
`else
  logic perf_unused_s;
  assign perf_unused_s = start_run_s ^ branch_hit_s;
`endif

endmodule
